// File: rtl/clock_period_meter_pkg.sv
// Shared definitions for the slow-clock period meter: FSM encoding and defaults.
package clock_period_meter_pkg;

  // IDLE waits for an arming edge; MEASURE counts between consecutive rises.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } meas_state_e;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;

endpackage : clock_period_meter_pkg

// File: rtl/clock_period_meter_sync_edge_detect.sv
// Synchroniser for an asynchronous slow clock with a registered rise pulse and
// a level output aligned to that pulse. Reusable by other slow-clock monitors.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   r_rise;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Synchroniser chain, delayed copy of the synced level, and registered rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_s_d  <= w_s;
      r_rise <= w_s & ~r_s_d;
    end
  end

  // r_s_d is the level that produced r_rise, so high-time counting lines up
  // with the edge the counters restart on.
  assign o_level = r_s_d;
  assign o_rise  = r_rise;

endmodule : sync_edge_detect

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous clock in clk cycles and
// flags a stopped or too-slow input.
//
// Handshake: valid is a one-cycle strobe with no ready; period/high_time are
// stable from the valid cycle until the next valid (they also hold over a stall).
module clock_period_meter
  import clock_period_meter_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             stalled,
  output meas_state_e      dbg_state
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic w_level;
  logic w_rise;

  meas_state_e      r_state,  w_state_nxt;
  logic [WIDTH-1:0] r_cnt,    w_cnt_nxt;
  logic [WIDTH-1:0] r_hcnt,   w_hcnt_nxt;
  logic [WIDTH-1:0] r_period, w_period_nxt;
  logic [WIDTH-1:0] r_high,   w_high_nxt;
  logic             r_valid,  w_valid_nxt;
  logic             r_locked, w_locked_nxt;
  logic             r_stalled, w_stalled_nxt;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (reset),
    .i_async (clk_in),
    .o_level (w_level),
    .o_rise  (w_rise)
  );

  // State, counters and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hcnt    <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_stalled <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_period  <= w_period_nxt;
      r_high    <= w_high_nxt;
      r_valid   <= w_valid_nxt;
      r_locked  <= w_locked_nxt;
      r_stalled <= w_stalled_nxt;
    end
  end

  // Next-state and datapath: a rise wins over saturation, so a period of
  // exactly CNT_MAX cycles is still measured rather than reported as a stall.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hcnt_nxt    = r_hcnt;
    w_period_nxt  = r_period;
    w_high_nxt    = r_high;
    w_valid_nxt   = 1'b0;
    w_locked_nxt  = r_locked;
    w_stalled_nxt = r_stalled;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_cnt_nxt   = CNT_ONE;
          w_hcnt_nxt  = CNT_ONE;
          w_state_nxt = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (w_rise) begin
          w_period_nxt  = r_cnt;
          w_high_nxt    = r_hcnt;
          w_valid_nxt   = 1'b1;
          w_locked_nxt  = 1'b1;
          w_stalled_nxt = 1'b0;
          w_cnt_nxt     = CNT_ONE;
          w_hcnt_nxt    = CNT_ONE;
        end else if (r_cnt == CNT_MAX) begin
          w_stalled_nxt = 1'b1;
          w_locked_nxt  = 1'b0;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_cnt_nxt  = r_cnt + CNT_ONE;
          w_hcnt_nxt = r_hcnt + {{(WIDTH-1){1'b0}}, w_level};
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign period    = r_period;
  assign high_time = r_high;
  assign valid     = r_valid;
  assign locked    = r_locked;
  assign stalled   = r_stalled;
  assign dbg_state = r_state;

endmodule : clock_period_meter

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter (WIDTH=8, SYNC_STAGES=2).
module tb_clock_period_meter;
  import clock_period_meter_pkg::*;

  localparam int W    = 8;
  localparam int SYNC = 2;

  logic         clk;
  logic         reset;
  logic         clk_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         locked;
  logic         stalled;
  meas_state_e  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  clock_period_meter #(
    .WIDTH       (W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_in    (clk_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .locked    (locked),
    .stalled   (stalled),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic reset_dut();
    reset  = 1'b1;
    clk_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
  endtask

  // ---------------- driver ----------------
  // Rising edge at c==0 of each period, offset ns after the clk edge.
  task automatic gen_clk(input int per, input int high, input int nper, input int offs);
    for (int p = 0; p < nper; p++) begin
      for (int c = 0; c < per; c++) begin
        @(posedge clk);
        #(offs);
        clk_in = (c < high);
      end
    end
    @(posedge clk);
    #(offs);
    clk_in = 1'b0;
  endtask

  // Drive a steady clk_in and check every valid in a window of win cycles.
  task automatic run_meas(input string name, input int per, input int high, input int nper,
                          input int offs, input int hmin, input int hmax,
                          input int exp_nv, input int win);
    int nv;
    int last;
    nv   = 0;
    last = -1;
    fork
      gen_clk(per, high, nper, offs);
      begin
        for (int cyc = 0; cyc < win; cyc++) begin
          @(posedge clk);
          #1;
          n_tests++;
          if (stalled !== 1'b0) begin
            n_fail++;
            $display("FAIL %s stalled: got %0b want 0 (cycle %0d)", name, stalled, cyc);
          end
          if (valid === 1'b1) begin
            nv++;
            n_tests++;
            if (period !== W'(per)) begin
              n_fail++;
              $display("FAIL %s period: got %0d want %0d", name, period, per);
            end
            n_tests++;
            if ((int'(high_time) < hmin) || (int'(high_time) > hmax)) begin
              n_fail++;
              $display("FAIL %s high_time: got %0d want %0d..%0d", name, high_time, hmin, hmax);
            end
            n_tests++;
            if (locked !== 1'b1) begin
              n_fail++;
              $display("FAIL %s locked: got %0b want 1", name, locked);
            end
            if (last >= 0) begin
              n_tests++;
              if (cyc - last != per) begin
                n_fail++;
                $display("FAIL %s valid spacing: got %0d want %0d", name, cyc - last, per);
              end
            end
            last = cyc;
          end
        end
      end
    join
    n_tests++;
    if (nv != exp_nv) begin
      n_fail++;
      $display("FAIL %s valid count: got %0d want %0d", name, nv, exp_nv);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset  = 1'b1;
    clk_in = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if ({period, high_time, valid, locked, stalled} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got p=%0d h=%0d v=%0b l=%0b s=%0b want all 0",
               period, high_time, valid, locked, stalled);
    end
    n_tests++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset state: got %0d want %0d", dbg_state, ST_IDLE);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_steady_6_3();
    reset_dut();
    // 8 rises: first arms, 7 measurements.
    run_meas("p6h3", 6, 3, 8, 3, 3, 3, 7, 58);
  endtask

  task automatic test_odd_7_4();
    reset_dut();
    run_meas("p7h4", 7, 4, 6, 7, 3, 5, 5, 55);
  endtask

  task automatic test_narrow_10_1();
    reset_dut();
    run_meas("p10h1", 10, 1, 5, 4, 1, 2, 4, 60);
  endtask

  task automatic test_exact_255();
    reset_dut();
    // Rise lands in the saturation cycle: must be measured, never stalled.
    run_meas("p255", 255, 100, 3, 3, 100, 100, 2, 2 * 255 + 15);
  endtask

  task automatic test_stall();
    int last_v;
    int stall_c;
    int nv;
    reset_dut();
    last_v  = -1;
    stall_c = -1;
    nv      = 0;
    fork
      gen_clk(6, 3, 4, 3);
      begin
        for (int cyc = 0; cyc < 700 && stall_c < 0; cyc++) begin
          @(posedge clk);
          #1;
          if (valid === 1'b1) begin
            nv++;
            last_v = cyc;
          end
          if (stalled === 1'b1) stall_c = cyc;
        end
      end
    join
    n_tests++;
    if (stall_c < 0) begin
      n_fail++;
      $display("FAIL stall timeout: got no stall want stall within 700 cycles");
    end else begin
      n_tests++;
      if (stall_c - last_v != 255) begin
        n_fail++;
        $display("FAIL stall delay: got %0d want 255", stall_c - last_v);
      end
      n_tests++;
      if (locked !== 1'b0) begin
        n_fail++;
        $display("FAIL stall locked: got %0b want 0", locked);
      end
      n_tests++;
      if (period !== W'(6) || high_time !== W'(3)) begin
        n_fail++;
        $display("FAIL stall hold: got p=%0d h=%0d want p=6 h=3", period, high_time);
      end
    end
    n_tests++;
    if (nv != 3) begin
      n_fail++;
      $display("FAIL stall valid count: got %0d want 3", nv);
    end
    // Resume: first rise only re-arms, stalled stays until the next valid.
    nv = 0;
    fork
      gen_clk(6, 3, 3, 3);
      begin
        for (int cyc = 0; cyc < 30 && nv == 0; cyc++) begin
          @(posedge clk);
          #1;
          if (valid === 1'b1) begin
            nv++;
            n_tests++;
            if (stalled !== 1'b0 || locked !== 1'b1 || period !== W'(6)) begin
              n_fail++;
              $display("FAIL resume valid: got s=%0b l=%0b p=%0d want s=0 l=1 p=6",
                       stalled, locked, period);
            end
          end else begin
            n_tests++;
            if (stalled !== 1'b1) begin
              n_fail++;
              $display("FAIL resume sticky: got %0b want 1 (cycle %0d)", stalled, cyc);
            end
          end
        end
      end
    join
    n_tests++;
    if (nv != 1) begin
      n_fail++;
      $display("FAIL resume no valid: got %0d want 1", nv);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    gen_clk(6, 3, 3, 3);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({period, high_time, valid, locked, stalled} !== '0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL mid reset: got p=%0d h=%0d v=%0b l=%0b s=%0b st=%0d want all 0",
               period, high_time, valid, locked, stalled, dbg_state);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    // Two rises after release: exactly one measurement.
    run_meas("post_reset", 6, 3, 2, 3, 3, 3, 1, 22);
  endtask

  task automatic test_latency();
    int n;
    reset_dut();
    @(posedge clk); #3; clk_in = 1'b1;
    @(posedge clk); #3; clk_in = 1'b0;
    repeat (8) @(posedge clk);
    @(posedge clk); #3; clk_in = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (valid === 1'b1) break;
    end
    n_tests++;
    if (valid !== 1'b1 || n != SYNC + 2) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles (valid=%0b) want %0d", n, valid, SYNC + 2);
    end
    n_tests++;
    if (period !== W'(10) || high_time < W'(1) || high_time > W'(2)) begin
      n_fail++;
      $display("FAIL latency meas: got p=%0d h=%0d want p=10 h=1..2", period, high_time);
    end
    @(posedge clk); #3; clk_in = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset  = 1'b1;
    clk_in = 1'b0;
    test_reset();
    test_steady_6_3();
    test_odd_7_4();
    test_narrow_10_1();
    test_exact_255();
    test_stall();
    test_reset_mid();
    test_latency();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_clock_period_meter
